// File: rtl/seq_pattern_detector_pkg.sv
// Shared types and constants for the programmable serial pattern detector.
package seq_pattern_detector_pkg;

   typedef enum logic [1:0] {
      UNCFG = 2'b00,
      FILL  = 2'b01,
      HUNT  = 2'b10
   } spd_state_t;

   localparam logic [1:0] ST_UNCFG = 2'b00;
   localparam logic [1:0] ST_FILL  = 2'b01;
   localparam logic [1:0] ST_HUNT  = 2'b10;

   // Smallest usable pattern length; larger lengths clamp to MAX_W in the top.
   localparam int LEN_MIN = 1;

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Data, configuration and status bundle of the pattern detector.
interface seq_pattern_detector_if #(
   parameter int MAX_W   = 16,
   parameter int COUNT_W = 8
);
   localparam int LEN_W = $clog2(MAX_W + 1);

   logic               din;
   logic               din_valid;
   logic               cfg_load;
   logic [MAX_W-1:0]   cfg_pattern;
   logic [LEN_W-1:0]   cfg_len;
   logic               cfg_overlap;
   logic               cnt_clr;
   logic               match;
   logic [COUNT_W-1:0] match_count;
   logic               armed;

   modport master (
      output din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      input  match, match_count, armed
   );

   modport slave (
      input  din, din_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
      output match, match_count, armed
   );
endinterface

// File: rtl/seq_pattern_detector_sat_counter.sv
// Saturating event counter with synchronous clear; clear beats increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next count: clear, saturating increment, or hold.
   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = {W{1'b0}};
      end else if (inc_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= {W{1'b0}};
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
endmodule

// File: rtl/seq_pattern_detector.sv
// Runtime-programmable serial pattern detector: shadow config, history shift
// register, fill tracking FSM, masked compare and a saturating match counter.
module seq_pattern_detector
   import seq_pattern_detector_pkg::*;
#(
   parameter int MAX_W   = 16,
   parameter int COUNT_W = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   seq_pattern_detector_if.slave   bus
);
   localparam int LEN_W = $clog2(MAX_W + 1);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_W);
   localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(LEN_MIN);

   logic [1:0]         state_q, state_d;
   logic [MAX_W-2:0]   hist_q, hist_d;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [MAX_W-1:0]   pat_q, pat_d;
   logic [MAX_W-1:0]   mask_q, mask_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               ovl_q, ovl_d;
   logic               match_q;

   logic [LEN_W-1:0]   len_eff_s;
   logic [MAX_W-1:0]   mask_s;
   logic [MAX_W-1:0]   window_s;
   logic [LEN_W-1:0]   fill_inc_s;
   logic               hit_s;
   logic [COUNT_W-1:0] count_s;

   // Clamp the requested length and build the compare mask for it.
   always_comb begin
      if (bus.cfg_len == {LEN_W{1'b0}}) begin
         len_eff_s = LEN_ONE;
      end else if (bus.cfg_len > LEN_MAX) begin
         len_eff_s = LEN_MAX;
      end else begin
         len_eff_s = bus.cfg_len;
      end
      mask_s = {MAX_W{1'b0}};
      for (int i = 0; i < MAX_W; i++) begin
         mask_s[i] = (LEN_W'(i) < len_eff_s);
      end
   end

   assign window_s   = {hist_q, bus.din};
   assign fill_inc_s = (fill_q == LEN_MAX) ? fill_q : (fill_q + LEN_ONE);
   // A load in the same cycle discards the incoming bit, so it can never hit.
   assign hit_s = (state_q == ST_HUNT) && bus.din_valid && !bus.cfg_load &&
                  (((window_s ^ pat_q) & mask_q) == {MAX_W{1'b0}});

   // Next-state logic for configuration, history, fill level and FSM.
   always_comb begin
      state_d = state_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      pat_d   = pat_q;
      mask_d  = mask_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      if (bus.cfg_load) begin
         pat_d   = bus.cfg_pattern;
         mask_d  = mask_s;
         len_d   = len_eff_s;
         ovl_d   = bus.cfg_overlap;
         hist_d  = {(MAX_W-1){1'b0}};
         fill_d  = {LEN_W{1'b0}};
         state_d = (len_eff_s == LEN_ONE) ? ST_HUNT : ST_FILL;
      end else if ((state_q != ST_UNCFG) && bus.din_valid) begin
         hist_d = window_s[MAX_W-2:0];
         if (hit_s && !ovl_q) begin
            // Non-overlapping: the next match must be built from fresh bits.
            fill_d  = {LEN_W{1'b0}};
            state_d = (len_q == LEN_ONE) ? ST_HUNT : ST_FILL;
         end else begin
            fill_d = fill_inc_s;
            if ((state_q == ST_FILL) && (fill_inc_s >= (len_q - LEN_ONE))) begin
               state_d = ST_HUNT;
            end else begin
               state_d = state_q;
            end
         end
      end else begin
         state_d = state_q;
      end
   end

   // State, history and shadow configuration registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_UNCFG;
         hist_q  <= {(MAX_W-1){1'b0}};
         fill_q  <= {LEN_W{1'b0}};
         pat_q   <= {MAX_W{1'b0}};
         mask_q  <= {MAX_W{1'b0}};
         len_q   <= {LEN_W{1'b0}};
         ovl_q   <= 1'b0;
         match_q <= 1'b0;
      end else begin
         state_q <= state_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         pat_q   <= pat_d;
         mask_q  <= mask_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         match_q <= hit_s;
      end
   end

   sat_counter #(.W(COUNT_W)) u_match_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (hit_s),
      .clr_i   (bus.cnt_clr),
      .count_o (count_s)
   );

   assign bus.match       = match_q;
   assign bus.match_count = count_s;
   assign bus.armed       = (state_q != ST_UNCFG);
endmodule
